// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter.
//   REG_ADDR_W : register index width
//   WB_DATA_W  : data width carried by a buffered long-latency result
//   wb_entry_t : one buffered long-latency result {rd, data}
//   wb_grant_e : which source owns the write port this cycle
package wb_arb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned WB_DATA_W  = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PIPE,
      GNT_FIFO,
      GNT_BYPASS
   } wb_grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer for long-latency unit results awaiting the write port.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (clears contents)
//   push, push_entry   : enqueue one entry (ignored when full)
//   pop                : dequeue the head (ignored when empty)
//   full, empty, head  : occupancy flags and oldest entry
//   entry_valid/rd     : per-slot valid flag and destination, for hazard compares
module wb_result_fifo
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  wb_entry_t                        push_entry,
   input  logic                             pop,
   output logic                             full,
   output logic                             empty,
   output wb_entry_t                        head,
   output logic [DEPTH-1:0]                 entry_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   wb_entry_t       mem_q [DEPTH];
   wb_entry_t       mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic            push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // A slot is live when its distance from the read pointer (mod DEPTH)
   // is below the occupancy count.
   always_comb begin
      entry_valid = '0;
      entry_rd    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entry_valid[i] = CW'(AW'(AW'(i) - rd_ptr_q)) < count_q;
         entry_rd[i]    = mem_q[i].rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between the W pipeline stage and a
// long-latency (mul/div) unit. LU results are buffered in a small FIFO; a
// starvation counter forces the FIFO head onto the port, stalling W.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_data     : W-stage write request
//   lu_valid/lu_ready/lu_rd/lu_data : LU result handshake
//   stall_w                       : freeze W and upstream this cycle
//   rf_we/rf_addr/rf_wdata        : register-file write port
//   q_rs1/q_rs2 -> busy_rs1/busy_rs2 : pending-LU-write hazard queries
// Option: define WB_ARB_BYPASS_EN to write an LU result straight to the port
// when the FIFO is empty and W is not writing.
module writeback_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_we,
   input  logic [REG_ADDR_W-1:0] pipe_rd,
   input  logic [WIDTH-1:0]      pipe_data,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_rd,
   input  logic [WIDTH-1:0]      lu_data,
   output logic                  stall_w,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_addr,
   output logic [WIDTH-1:0]      rf_wdata,
   input  logic [REG_ADDR_W-1:0] q_rs1,
   input  logic [REG_ADDR_W-1:0] q_rs2,
   output logic                  busy_rs1,
   output logic                  busy_rs2
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic                                 pipe_req;
   logic                                 fifo_full, fifo_empty;
   logic                                 fifo_push, fifo_pop;
   logic                                 force_fifo, bypass;
   wb_entry_t                            fifo_head, lu_entry;
   logic [FIFO_DEPTH-1:0]                entry_valid;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
   wb_grant_e                            grant;
   logic [SW-1:0]                        starve_q, starve_d;

   // Writes to x0 never occupy the port.
   assign pipe_req = pipe_we && (pipe_rd != '0);
   assign lu_ready = !fifo_full;

`ifdef WB_ARB_BYPASS_EN
   assign bypass = fifo_empty && !pipe_req && lu_valid && (lu_rd != '0);
`else
   assign bypass = 1'b0;
`endif

   // Entry data is fixed at WB_DATA_W; casts adapt it to WIDTH.
   assign lu_entry.rd   = lu_rd;
   assign lu_entry.data = WB_DATA_W'(lu_data);

   // rd==0 results are accepted but dropped; no same-cycle pass-through when full.
   assign fifo_push  = lu_valid && lu_ready && (lu_rd != '0) && !bypass;
   assign fifo_pop   = (grant == GNT_FIFO);
   assign force_fifo = !fifo_empty && ((starve_q == SW'(STARVE_LIMIT)) || fifo_full);

   wb_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (fifo_push),
      .push_entry  (lu_entry),
      .pop         (fifo_pop),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .head        (fifo_head),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   always_comb begin
      grant   = GNT_NONE;
      stall_w = 1'b0;
      if (force_fifo) begin
         grant   = GNT_FIFO;
         stall_w = pipe_req;
      end else if (pipe_req) begin
         grant = GNT_PIPE;
      end else if (!fifo_empty) begin
         grant = GNT_FIFO;
      end else if (bypass) begin
         grant = GNT_BYPASS;
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_addr  = '0;
      rf_wdata = '0;
      unique case (grant)
         GNT_PIPE: begin
            rf_we    = 1'b1;
            rf_addr  = pipe_rd;
            rf_wdata = pipe_data;
         end
         GNT_FIFO: begin
            rf_we    = 1'b1;
            rf_addr  = fifo_head.rd;
            rf_wdata = WIDTH'(fifo_head.data);
         end
         GNT_BYPASS: begin
            rf_we    = 1'b1;
            rf_addr  = lu_rd;
            rf_wdata = lu_data;
         end
         default: ;
      endcase
      // W may still present a request while reset is held; suppress it.
      if (!rst_n) begin
         rf_we = 1'b0;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || (grant == GNT_FIFO)) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   always_comb begin
      busy_rs1 = 1'b0;
      busy_rs2 = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i] && (q_rs1 != '0) && (entry_rd[i] == q_rs1)) busy_rs1 = 1'b1;
         if (entry_valid[i] && (q_rs2 != '0) && (entry_rd[i] == q_rs2)) busy_rs2 = 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, a reset
// mid-operation sequence, and randomized traffic against a queue-based model.
module tb_writeback_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned W = 32;
   localparam int unsigned D = 2;
   localparam int unsigned L = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pipe_we;
   logic [4:0]   pipe_rd;
   logic [W-1:0] pipe_data;
   logic         lu_valid;
   logic         lu_ready;
   logic [4:0]   lu_rd;
   logic [W-1:0] lu_data;
   logic         stall_w;
   logic         rf_we;
   logic [4:0]   rf_addr;
   logic [W-1:0] rf_wdata;
   logic [4:0]   q_rs1, q_rs2;
   logic         busy_rs1, busy_rs2;

   writeback_arbiter #(
      .WIDTH        (W),
      .FIFO_DEPTH   (D),
      .STARVE_LIMIT (L)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pipe_we   (pipe_we),
      .pipe_rd   (pipe_rd),
      .pipe_data (pipe_data),
      .lu_valid  (lu_valid),
      .lu_ready  (lu_ready),
      .lu_rd     (lu_rd),
      .lu_data   (lu_data),
      .stall_w   (stall_w),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .q_rs1     (q_rs1),
      .q_rs2     (q_rs2),
      .busy_rs1  (busy_rs1),
      .busy_rs2  (busy_rs2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                        input logic [4:0] q1, input logic [4:0] q2);
      pipe_we = pwe; pipe_rd = prd; pipe_data = pdata;
      lu_valid = lv; lu_rd = lrd; lu_data = ldata;
      q_rs1 = q1; q_rs2 = q2;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        pwe;  logic [4:0] prd;  logic [31:0] pdata;
      logic        lv;   logic [4:0] lrd;  logic [31:0] ldata;
      logic [4:0]  q1;   logic [4:0] q2;
      logic        we;   logic [4:0] addr; logic [31:0] wdata;
      logic        stall; logic rdy; logic b1; logic b2;
   } vec_t;

   function automatic vec_t mk(
         input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
         input logic [4:0] q1, input logic [4:0] q2,
         input logic we, input logic [4:0] addr, input logic [31:0] wdata,
         input logic stall, input logic rdy, input logic b1, input logic b2);
      vec_t v;
      v.pwe = pwe; v.prd = prd; v.pdata = pdata;
      v.lv = lv; v.lrd = lrd; v.ldata = ldata;
      v.q1 = q1; v.q2 = q2;
      v.we = we; v.addr = addr; v.wdata = wdata;
      v.stall = stall; v.rdy = rdy; v.b1 = b1; v.b2 = b2;
      return v;
   endfunction

   vec_t vecs [19];

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   mstarve;

   // Checks the current cycle's outputs and advances the model past the edge.
   task automatic model_cycle(output logic exp_stall);
      bit preq, full, empty, frc, byp, fg;
      bit e_we, b1, b2;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      preq  = pipe_we && (pipe_rd != 0);
      full  = (mq.size() == D);
      empty = (mq.size() == 0);
      frc   = !empty && (mstarve == L || full);
      byp   = 0;
`ifdef WB_ARB_BYPASS_EN
      byp   = empty && !preq && lu_valid && (lu_rd != 0);
`endif
      e_we = 0; e_addr = 0; e_data = 0; exp_stall = 0; fg = 0;
      if (frc) begin
         e_we = 1; e_addr = mq[0].rd; e_data = mq[0].data; exp_stall = preq; fg = 1;
      end else if (preq) begin
         e_we = 1; e_addr = pipe_rd; e_data = pipe_data;
      end else if (!empty) begin
         e_we = 1; e_addr = mq[0].rd; e_data = mq[0].data; fg = 1;
      end else if (byp) begin
         e_we = 1; e_addr = lu_rd; e_data = lu_data;
      end
      b1 = 0; b2 = 0;
      foreach (mq[k]) begin
         if (q_rs1 != 0 && mq[k].rd == q_rs1) b1 = 1;
         if (q_rs2 != 0 && mq[k].rd == q_rs2) b2 = 1;
      end
      chk("rnd.rf_we", 32'(rf_we), 32'(e_we));
      if (e_we) begin
         chk("rnd.rf_addr", 32'(rf_addr), 32'(e_addr));
         chk("rnd.rf_wdata", rf_wdata, e_data);
      end
      chk("rnd.stall_w", 32'(stall_w), 32'(exp_stall));
      chk("rnd.lu_ready", 32'(lu_ready), 32'(!full));
      chk("rnd.busy_rs1", 32'(busy_rs1), 32'(b1));
      chk("rnd.busy_rs2", 32'(busy_rs2), 32'(b2));
      if (fg) void'(mq.pop_front());
      if (lu_valid && !full && lu_rd != 0 && !byp) begin
         ent_t e;
         e.rd = lu_rd; e.data = lu_data;
         mq.push_back(e);
      end
      if (fg || empty) mstarve = 0;
      else if (mstarve < L) mstarve = mstarve + 1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic hold;
      // Rows follow the directed plan; rows 2..4 differ when bypass is built in.
      vecs[0]  = mk(0,0,0,        0,0,0,          0,0,   0,0,0,        0,1,0,0);
      vecs[1]  = mk(1,5,'hA5,     0,0,0,          0,0,   1,5,'hA5,     0,1,0,0);
`ifdef WB_ARB_BYPASS_EN
      vecs[2]  = mk(0,0,0,        1,7,'h1234,     7,0,   1,7,'h1234,   0,1,0,0);
      vecs[3]  = mk(0,0,0,        0,0,0,          7,0,   0,0,0,        0,1,0,0);
`else
      vecs[2]  = mk(0,0,0,        1,7,'h1234,     7,0,   0,0,0,        0,1,0,0);
      vecs[3]  = mk(0,0,0,        0,0,0,          7,0,   1,7,'h1234,   0,1,1,0);
`endif
      vecs[4]  = mk(0,0,0,        0,0,0,          7,0,   0,0,0,        0,1,0,0);
      vecs[5]  = mk(1,3,'h30,     1,9,'h99,       0,0,   1,3,'h30,     0,1,0,0);
      vecs[6]  = mk(1,3,'h31,     0,0,0,          9,0,   1,3,'h31,     0,1,1,0);
      vecs[7]  = mk(1,3,'h32,     0,0,0,          9,0,   1,3,'h32,     0,1,1,0);
      vecs[8]  = mk(1,3,'h33,     0,0,0,          9,0,   1,3,'h33,     0,1,1,0);
      vecs[9]  = mk(1,3,'h34,     0,0,0,          9,0,   1,3,'h34,     0,1,1,0);
      vecs[10] = mk(1,3,'h35,     0,0,0,          9,0,   1,9,'h99,     1,1,1,0);
      vecs[11] = mk(1,3,'h35,     0,0,0,          9,0,   1,3,'h35,     0,1,0,0);
      vecs[12] = mk(1,4,'h40,     1,10,'hAA,      0,0,   1,4,'h40,     0,1,0,0);
      vecs[13] = mk(1,4,'h41,     1,11,'hBB,      10,0,  1,4,'h41,     0,1,1,0);
      vecs[14] = mk(1,4,'h42,     1,12,'hCC,      11,10, 1,10,'hAA,    1,0,1,1);
      vecs[15] = mk(1,4,'h42,     1,12,'hCC,      11,10, 1,4,'h42,     0,1,1,0);
      vecs[16] = mk(1,0,'h77,     0,0,0,          12,11, 1,11,'hBB,    0,0,1,1);
      vecs[17] = mk(1,0,'hDEAD,   0,0,0,          12,0,  1,12,'hCC,    0,1,1,0);
      vecs[18] = mk(1,0,'hDEAD,   0,0,0,          12,0,  0,0,0,        0,1,0,0);

      // Reset state, with a live W request that must not reach the port.
      rst_n = 1'b0;
      drive(1, 5, 'h55, 0, 0, 0, 5, 5);
      #1;
      @(negedge clk);
      chk("reset.rf_we", 32'(rf_we), 0);
      chk("reset.lu_ready", 32'(lu_ready), 1);
      chk("reset.stall_w", 32'(stall_w), 0);
      chk("reset.busy_rs1", 32'(busy_rs1), 0);
      chk("reset.busy_rs2", 32'(busy_rs2), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdata,
               vecs[i].lv, vecs[i].lrd, vecs[i].ldata, vecs[i].q1, vecs[i].q2);
         #1;
         chk($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(vecs[i].we));
         if (vecs[i].we) begin
            chk($sformatf("vec%0d.rf_addr", i), 32'(rf_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d.rf_wdata", i), rf_wdata, vecs[i].wdata);
         end
         chk($sformatf("vec%0d.stall_w", i), 32'(stall_w), 32'(vecs[i].stall));
         chk($sformatf("vec%0d.lu_ready", i), 32'(lu_ready), 32'(vecs[i].rdy));
         chk($sformatf("vec%0d.busy_rs1", i), 32'(busy_rs1), 32'(vecs[i].b1));
         chk($sformatf("vec%0d.busy_rs2", i), 32'(busy_rs2), 32'(vecs[i].b2));
      end

      // Reset with two entries queued.
      @(negedge clk); drive(1, 6, 'h1, 1, 13, 'hD1, 0, 0);
      @(negedge clk); drive(1, 6, 'h2, 1, 14, 'hD2, 0, 0);
      @(negedge clk); drive(1, 6, 'h3, 0, 0, 0, 13, 14);
      #1;
      chk("midrst.pre_busy_rs1", 32'(busy_rs1), 1);
      chk("midrst.pre_busy_rs2", 32'(busy_rs2), 1);
      chk("midrst.pre_lu_ready", 32'(lu_ready), 0);
      rst_n = 1'b0;
      #1;
      chk("midrst.rf_we", 32'(rf_we), 0);
      chk("midrst.lu_ready", 32'(lu_ready), 1);
      chk("midrst.stall_w", 32'(stall_w), 0);
      chk("midrst.busy_rs1", 32'(busy_rs1), 0);
      chk("midrst.busy_rs2", 32'(busy_rs2), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 13, 14);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("postrst.rf_we", 32'(rf_we), 0);
      chk("postrst.busy_rs1", 32'(busy_rs1), 0);
      chk("postrst.busy_rs2", 32'(busy_rs2), 0);

      // Randomized traffic; a stalled W request is held for the next cycle.
      mq.delete();
      mstarve = 0;
      hold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!hold) begin
            pipe_we   = ($urandom_range(0, 99) < 70);
            pipe_rd   = 5'($urandom_range(0, 7));
            pipe_data = $urandom;
         end
         lu_valid = ($urandom_range(0, 99) < 40);
         lu_rd    = 5'($urandom_range(0, 15));
         lu_data  = $urandom;
         q_rs1    = 5'($urandom_range(0, 15));
         q_rs2    = 5'($urandom_range(0, 15));
         #1;
         model_cycle(hold);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single register-file write port between two sources.
- Source 1: the in-order pipeline Writeback stage, driven from the W-stage pipeline register outputs (RegWriteW, RdW, selected result).
- Source 2: a long-latency execution unit (multiply/divide) whose results complete out of band.
- Long-latency results are buffered in a small FIFO; a starvation counter guarantees they drain.
- The arbiter stalls the pipeline when it must take the write port from the W stage.

Parameters:
- WIDTH, 32, data width of register-file write data.
- FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive denied cycles before the FIFO head is forced onto the port.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_we  in  1  W-stage register write request (RegWriteW).
- pipe_rd  in  5  W-stage destination register (RdW).
- pipe_data  in  WIDTH  W-stage result (ResultW).
- lu_valid  in  1  long-latency unit result valid.
- lu_ready  out  1  arbiter can accept an LU result.
- lu_rd  in  5  LU destination register.
- lu_data  in  WIDTH  LU result.
- stall_w  out  1  freeze the W-stage register and everything upstream this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_wdata  out  WIDTH  register-file write data.
- q_rs1, q_rs2  in  5 each  hazard-unit source queries.
- busy_rs1, busy_rs2  out  1 each  query matches a valid FIFO entry (rd != 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- On reset:
  - FIFO empty, pointers 0, starve counter 0.
  - lu_ready=1, stall_w=0, busy_*=0.
  - rf_we=0 while rst_n is low.
- Effective pipeline request: pipe_req = pipe_we && pipe_rd != 0. Writes to x0 are discarded and never occupy the port.
- Enqueue:
  - Occurs on a rising edge when lu_valid && lu_ready.
  - lu_ready = !full; combinational from state only, with no dependency on lu_valid.
  - An lu_rd==0 result is accepted and dropped (not enqueued).
- Grant, evaluated each cycle (combinational):
  - force = fifo_nonempty && (starve_cnt == STARVE_LIMIT || full).
  - If force: FIFO head granted, stall_w = pipe_req, head dequeued at the edge.
  - Else if pipe_req: pipeline granted, stall_w=0.
  - Else if fifo_nonempty: FIFO head granted.
  - Else: rf_we=0.
- Write port: rf_addr/rf_wdata come from the granted source; rf_we=1 iff a grant occurred.
- Stalled W-stage instruction: re-presented unchanged next cycle and written then, unless force is still true.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and not granted.
  - Clears on any FIFO grant or when the FIFO is empty.
- Latency: an enqueued result is written no earlier than the cycle after acceptance (without the bypass feature).
- Full plus simultaneous lu_valid: no acceptance (lu_ready=0). A dequeue in the same cycle does not open a slot until the next cycle (no pass-through).
- Ordering: FIFO drains strictly in order. WAW ordering between the pipeline and the LU is the hazard unit's responsibility, via busy_rs*.
- Reset mid-operation: FIFO contents are discarded immediately and no write is issued.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_req=0 and lu_valid with lu_rd != 0, the LU result is written the same cycle directly to the port and is not enqueued (zero latency).
- Undefined: all LU results pass through the FIFO.

Decomposition:
- Package wb_arb_pkg:
  - REG_ADDR_W=5.
  - typedef struct wb_entry_t {rd, data}.
  - grant enum {GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_BYPASS}.
- Sub-module wb_result_fifo:
  - Parameterised depth, wb_entry_t storage.
  - Ports: push/pop/full/empty/head plus a per-entry valid/rd vector for the busy compare.
- Arbitration, starve counter and busy compare stay in writeback_arbiter.

Test Plan:
- Idle LU; pipe_we=1, pipe_rd=5, pipe_data=0xA5 -> rf_we=1, rf_addr=5, rf_wdata=0xA5, stall_w=0 in the same cycle.
- LU result rd=7, data=0x1234; pipeline idle -> written the next cycle; busy_rs1=1 for q_rs1=7 until that write, 0 after.
- LU enqueues rd=9; pipe_req held high continuously -> FIFO denied 4 cycles. Cycle 5: rf_addr=9, stall_w=1. Cycle 6: pipeline write proceeds, stall_w=0.
- Fill FIFO with 2 results while pipe_req is high -> lu_ready=0. Next cycle: force drain with stall_w=1. lu_ready returns to 1 the cycle after the dequeue.
- pipe_we=1, pipe_rd=0 with the FIFO non-empty -> FIFO head written; no write to x0.
- Assert rst_n=0 with 2 entries queued -> lu_ready=1, busy_*=0, rf_we=0 immediately. With WB_ARB_BYPASS_EN, an LU result on an empty FIFO with pipeline idle is written in the same cycle.
